// File: rtl/serial_paralelo_2b.sv
// 2-bit serial lane to 9-bit word deserializer with 0xBC comma alignment (clk16f domain).
// Optional SP_IDLE_COUNT_EN adds an idle_count output tracking consecutive idle groups.
module serial_paralelo_2b #(
  parameter int unsigned BC_LOCK = 4,
  parameter logic [7:0]  BC_BYTE = 8'hBC
) (
  input  logic       clk16f,
  input  logic       reset,
  input  logic [1:0] serial,
  output logic [8:0] paralelo,
  output logic       word_strobe,
  output logic       active
`ifdef SP_IDLE_COUNT_EN
  ,
  output logic [7:0] idle_count
`endif
);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] ALIGN  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;
  logic [1:0] ph;
  logic [1:0] lock_phase;
  logic [1:0] lock_phase_next;
  logic [7:0] sr;
  logic [7:0] sr_next;
  logic [2:0] fill;
  logic [3:0] bc_cnt;
  logic [3:0] bc_cnt_next;
  logic       pend;
  logic       filled;
  logic       is_bc;
  logic       at_phase;

  // Comparisons look at the shift register as it will be after this edge.
  always_comb begin
    sr_next  = {sr[5:0], serial};
    filled   = (fill >= 3'd3);
    is_bc    = (sr_next == BC_BYTE);
    at_phase = (ph == lock_phase);
  end

  // Alignment state machine: search, confirm BC_LOCK aligned commas, then stay locked.
  always_comb begin
    state_next      = state;
    lock_phase_next = lock_phase;
    bc_cnt_next     = bc_cnt;
    case (state)
      SEARCH: begin
        if (filled && is_bc) begin
          lock_phase_next = ph;
          bc_cnt_next     = 4'd1;
          state_next      = (BC_LOCK == 32'd1) ? LOCKED : ALIGN;
        end else begin
          state_next = SEARCH;
        end
      end
      ALIGN: begin
        if (at_phase) begin
          if (is_bc) begin
            bc_cnt_next = bc_cnt + 4'd1;
            if (bc_cnt_next == 4'(BC_LOCK)) begin
              state_next = LOCKED;
            end else begin
              state_next = ALIGN;
            end
          end else begin
            bc_cnt_next = 4'd0;
            state_next  = SEARCH;
          end
        end else begin
          state_next = ALIGN;
        end
      end
      LOCKED: begin
        state_next = LOCKED;
      end
      default: begin
        state_next  = SEARCH;
        bc_cnt_next = 4'd0;
      end
    endcase
  end

  // Symbol shifting, phase/fill counters and alignment state registers.
  always_ff @(posedge clk16f or posedge reset) begin
    if (reset) begin
      state      <= SEARCH;
      ph         <= 2'd0;
      lock_phase <= 2'd0;
      sr         <= 8'h00;
      fill       <= 3'd0;
      bc_cnt     <= 4'd0;
      active     <= 1'b0;
      pend       <= 1'b0;
    end else begin
      sr         <= sr_next;
      ph         <= ph + 2'd1;
      fill       <= (fill == 3'd4) ? 3'd4 : fill + 3'd1;
      state      <= state_next;
      lock_phase <= lock_phase_next;
      bc_cnt     <= bc_cnt_next;
      active     <= (state_next == LOCKED);
      pend       <= (state == LOCKED) && at_phase;
    end
  end

  // A group completed at the previous edge is now whole in sr; publish it.
  always_ff @(posedge clk16f or posedge reset) begin
    if (reset) begin
      paralelo    <= 9'h000;
      word_strobe <= 1'b0;
    end else begin
      word_strobe <= pend;
      if (pend) begin
        paralelo <= (sr == BC_BYTE) ? 9'h000 : {1'b1, sr};
      end else begin
        paralelo <= paralelo;
      end
    end
  end

`ifdef SP_IDLE_COUNT_EN
  // Saturating run length of idle groups, cleared by any valid word.
  always_ff @(posedge clk16f or posedge reset) begin
    if (reset) begin
      idle_count <= 8'h00;
    end else if (pend) begin
      if (sr == BC_BYTE) begin
        idle_count <= (idle_count == 8'hFF) ? 8'hFF : idle_count + 8'd1;
      end else begin
        idle_count <= 8'h00;
      end
    end else begin
      idle_count <= idle_count;
    end
  end
`endif

endmodule

// File: tb/tb_serial_paralelo_2b.sv
// Directed self-checking bench for serial_paralelo_2b (alignment, decode, reset, optional idle count).
module tb_serial_paralelo_2b;

  logic       clk16f = 1'b0;
  logic       reset;
  logic [1:0] serial;
  logic [8:0] paralelo;
  logic       word_strobe;
  logic       active;
`ifdef SP_IDLE_COUNT_EN
  logic [7:0] idle_count;
`endif

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int base;

  serial_paralelo_2b dut (
    .clk16f      (clk16f),
    .reset       (reset),
    .serial      (serial),
    .paralelo    (paralelo),
    .word_strobe (word_strobe),
    .active      (active)
`ifdef SP_IDLE_COUNT_EN
    ,
    .idle_count  (idle_count)
`endif
  );

  always #5 clk16f = ~clk16f;

  // Counts strobe cycles, sampled mid-cycle.
  always @(negedge clk16f) begin
    if (word_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one symbol, let the DUT take it, then settle past the edge.
  task automatic sym(input logic [1:0] s);
    serial = s;
    @(posedge clk16f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    sym(b[7:6]);
    sym(b[5:4]);
    sym(b[3:2]);
    sym(b[1:0]);
  endtask

  initial begin
    reset  = 1'b1;
    serial = 2'b00;
    @(posedge clk16f);
    #1;
    check("reset_state", {5'd0, paralelo, word_strobe, active}, 16'h0000);
`ifdef SP_IDLE_COUNT_EN
    check("reset_idle", {8'd0, idle_count}, 16'h0000);
`endif
    reset = 1'b0;

    // Reset check: idle zeros for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      sym(2'b00);
      check("zeros_hold", {5'd0, paralelo, word_strobe, active}, 16'h0000);
    end
    check("zeros_no_strobe", 16'(strobe_cnt), 16'd0);

    // Aligned lock.
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'hBC);
    check("align_3bc_inactive", {15'd0, active}, 16'd0);
    send_byte(8'hBC);
    check("align_4bc_active", {15'd0, active}, 16'd1);
    check("align_no_strobe", 16'(strobe_cnt), 16'd0);

    // Idle group after lock, then data 0xA5.
    send_byte(8'hBC);
    check("idle_pre_strobe", {15'd0, word_strobe}, 16'd0);
    sym(2'b10);
    check("idle_strobe", {5'd0, paralelo, word_strobe, active}, {5'd0, 9'h000, 1'b1, 1'b1});
    sym(2'b10);
    sym(2'b01);
    sym(2'b01);
    check("a5_pre_strobe", {5'd0, paralelo, word_strobe}, {6'd0, 9'h000, 1'b0});
    sym(2'b10);
    check("a5_strobe", {5'd0, paralelo, word_strobe}, {6'd0, 9'h1A5, 1'b1});
    sym(2'b11);
    check("a5_hold", {5'd0, paralelo, word_strobe}, {6'd0, 9'h1A5, 1'b0});
    sym(2'b11);
    sym(2'b00);
    check("a5_hold2", {7'd0, paralelo}, {7'd0, 9'h1A5});

    // Streaming 0x5A, then reset mid-LOCKED.
    sym(2'b01);
    check("bc_after_a5", {5'd0, paralelo, word_strobe}, {6'd0, 9'h000, 1'b1});
    sym(2'b01);
    sym(2'b10);
    sym(2'b10);
    sym(2'b00);
    check("5a_strobe", {5'd0, paralelo, word_strobe}, {6'd0, 9'h15A, 1'b1});
    reset = 1'b1;
    #2;
    check("async_reset", {5'd0, paralelo, word_strobe, active}, 16'h0000);
`ifdef SP_IDLE_COUNT_EN
    check("async_reset_idle", {8'd0, idle_count}, 16'h0000);
`endif
    @(posedge clk16f);
    #1;
    reset = 1'b0;
    base  = strobe_cnt;
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'hBC);
    check("relock_3bc_inactive", {15'd0, active}, 16'd0);
    check("relock_no_strobe", 16'(strobe_cnt - base), 16'd0);
    send_byte(8'hBC);
    check("relock_4bc_active", {15'd0, active}, 16'd1);
    send_byte(8'hBC);
    send_byte(8'hBC);
`ifdef SP_IDLE_COUNT_EN
    check("idle_count_1", {8'd0, idle_count}, 16'd1);
`endif
    send_byte(8'hBC);
`ifdef SP_IDLE_COUNT_EN
    check("idle_count_2", {8'd0, idle_count}, 16'd2);
`endif
    send_byte(8'h5A);
    check("idle_par_zero", {7'd0, paralelo}, 16'h0000);
`ifdef SP_IDLE_COUNT_EN
    check("idle_count_3", {8'd0, idle_count}, 16'd3);
`endif
    sym(2'b00);
    check("relock_5a", {5'd0, paralelo, word_strobe}, {6'd0, 9'h15A, 1'b1});
`ifdef SP_IDLE_COUNT_EN
    check("idle_count_clear", {8'd0, idle_count}, 16'd0);
`endif

    // Misaligned start: one extra symbol shifts the byte boundary.
    reset = 1'b1;
    @(posedge clk16f);
    #1;
    reset = 1'b0;
    sym(2'b01);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'hBC);
    check("mis_3bc_inactive", {15'd0, active}, 16'd0);
    send_byte(8'hBC);
    check("mis_4bc_active", {15'd0, active}, 16'd1);
    send_byte(8'hBC);
    sym(2'b00);
    check("mis_idle_strobe", {5'd0, paralelo, word_strobe}, {6'd0, 9'h000, 1'b1});
    sym(2'b11);
    sym(2'b11);
    sym(2'b00);
    check("mis_3c_pre", {15'd0, word_strobe}, 16'd0);
    sym(2'b00);
    check("mis_3c_strobe", {5'd0, paralelo, word_strobe}, {6'd0, 9'h13C, 1'b1});

    // Broken alignment: 2 BCs, 0x55, then 4 fresh BCs.
    reset = 1'b1;
    @(posedge clk16f);
    #1;
    reset = 1'b0;
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h55);
    check("brk_after_55", {15'd0, active}, 16'd0);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'hBC);
    check("brk_3bc_inactive", {15'd0, active}, 16'd0);
    send_byte(8'hBC);
    check("brk_4bc_active", {15'd0, active}, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_paralelo_2b.md
Name: serial_paralelo_2b

Overview:
Receive-side deserializer that consumes the 2-bit-per-cycle serial lane produced by the transmit paralelo-to-serial stage. It searches the incoming symbol stream for the 0xBC idle/comma byte and aligns to its byte boundary. Once locked, it reassembles each 4-symbol group into a 9-bit word: a valid bit plus 8 data bits. It sits directly after the serial link, in the clk16f domain.

Parameters:
BC_LOCK, 4, consecutive aligned 0xBC bytes required to declare lock (legal range 1..15)
BC_BYTE, 8'hBC, idle/comma byte value

Ports:
clk16f  input  1  symbol-rate clock; all logic is on the rising edge
reset  input  1  asynchronous, active-high reset
serial  input  2  incoming symbol; serial[1] is the more significant bit
paralelo  output  9  [8]=valid, [7:0]=data byte, MSB-first reassembly
word_strobe  output  1  one-cycle pulse whenever paralelo is updated
active  output  1  high while the block is in LOCKED

Behaviour:
- Reset (asynchronous assert, takes effect immediately):
  - paralelo=9'h000, word_strobe=0, active=0.
  - State=SEARCH, phase counter ph=0, shift register sr=8'h00, fill counter=0, bc_cnt=0.
- Every clock: sr <= {sr[5:0], serial}. ph increments mod 4 and free-runs from reset.
- Fill counter saturates at 4. No comparison against BC_BYTE is made until the fill counter has reached 4.
- Comparisons use the value of sr after the current shift, i.e. the 4 most recent symbols including the one sampled at this edge.
- SEARCH:
  - On any cycle where filled and the post-shift sr==BC_BYTE: lock_phase<=ph, bc_cnt<=1.
  - If BC_LOCK==1, go to LOCKED; otherwise go to ALIGN.
- ALIGN: only evaluated on cycles where ph==lock_phase.
  - sr==BC_BYTE: bc_cnt++. When bc_cnt reaches BC_LOCK, go to LOCKED.
  - sr!=BC_BYTE: bc_cnt<=0 and return to SEARCH. The search restarts on the next cycle at any phase.
- LOCKED: active=1.
  - On each cycle where ph==lock_phase: word_strobe=1 on the following cycle, and paralelo is registered on that same following cycle.
  - If sr==BC_BYTE, paralelo<=9'h000 (idle: valid=0, data cleared).
  - Otherwise paralelo<={1'b1, sr}.
  - paralelo holds its value between strobes. word_strobe is 0 on all other cycles.
- Latency: the 4th symbol of a byte is sampled at edge k; paralelo and word_strobe update at edge k+1.
- Lock persistence: LOCKED is left only by reset. Data bytes equal to BC_BYTE are always decoded as idle; the upstream stage never sends 0xBC as valid data.
- The first word_strobe after entering LOCKED corresponds to the byte group that completes 4 cycles after the locking BC.
- No strobes are produced in SEARCH or ALIGN; paralelo keeps its reset value there.
- Reset mid-operation: all state returns to reset values immediately. Lock must then be reacquired with BC_LOCK fresh BCs.

Optional Feature:
SP_IDLE_COUNT_EN
- Defined: adds output idle_count[7:0].
  - Reset value 0.
  - Increments by 1 on each LOCKED strobe that decodes an idle (BC_BYTE) group.
  - Saturates at 8'hFF.
  - Clears to 0 on the cycle a valid word is decoded.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset check: reset high then low, serial=2'b00 held 20 cycles -> paralelo=9'h000, word_strobe=0, active=0 throughout.
- Aligned lock: send BC as symbols 10,11,11,00 repeated 4 times -> active rises in the cycle after the 4th BC completes. Next BC group -> strobe with paralelo=9'h000.
- Data decode: locked, then send 0xA5 as 10,10,01,01 -> one-cycle word_strobe with paralelo=9'h1A5 one cycle after the last symbol is sampled. Value holds until the next strobe.
- Misaligned start: one extra symbol 2'b01 before 5 BCs -> lock acquired at lock_phase offset by 1. Following 0x3C (00,11,11,00) -> paralelo=9'h13C.
- Broken alignment: 2 BCs, then 0x55, then 4 BCs -> state returns to SEARCH after 0x55. active rises only after the later 4 consecutive BCs.
- Reset mid-LOCKED: assert reset while locked and streaming 0x5A -> active=0 and paralelo=9'h000 immediately. No strobes until 4 new BCs. With SP_IDLE_COUNT_EN defined, idle_count goes 1,2,3 over 3 idle groups and clears on the next data word.
